// File: rtl/spi_reg_bridge.sv
// Byte-level SPI-to-register transaction engine: command, multi-byte address, and an
// auto-incrementing read/write data burst with range checking and read prefetch.
module spi_reg_bridge #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned REG_COUNT = 256,
  parameter logic [7:0]  ERR_BYTE  = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic [7:0]        tx_byte,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              err
);

  localparam int         ADDR_BYTES = ADDR_W / 8;
  localparam logic [1:0] LAST_CNT   = 2'(ADDR_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WRITE,
    S_READ
  } state_t;

  state_t            state, state_d;
  logic              cmd_rd, cmd_rd_d;
  logic              cmd_noinc, cmd_noinc_d;
  logic [1:0]        byte_cnt, byte_cnt_d;
  logic [ADDR_W-1:0] cur_addr, cur_addr_d;
  logic [ADDR_W-1:0] reg_addr_d;
  logic [7:0]        reg_wdata_d;
  logic              we_d, re_d, err_d;
  logic              wr_fire, rd_issue;
  logic              rd_err_d;
  logic              rd_err_p1;
  logic              rd_vld_p2, rd_err_p2;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return 32'(a) < REG_COUNT;
  endfunction

  // Addresses at or above REG_COUNT count on modulo 2**ADDR_W instead of wrapping early.
  function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a,
                                                  input logic hold);
    if (hold)
      return a;
    if (32'(a) == REG_COUNT - 1)
      return '0;
    return a + ADDR_W'(1);
  endfunction

  always_comb begin
    state_d     = state;
    cmd_rd_d    = cmd_rd;
    cmd_noinc_d = cmd_noinc;
    byte_cnt_d  = byte_cnt;
    cur_addr_d  = cur_addr;
    reg_wdata_d = reg_wdata;
    we_d        = 1'b0;
    re_d        = 1'b0;
    err_d       = 1'b0;
    rd_err_d    = 1'b0;
    wr_fire     = 1'b0;
    rd_issue    = 1'b0;

    if (cs_n) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_d = S_CMD;
        S_CMD: begin
          if (rx_valid) begin
            cmd_rd_d    = rx_byte[7];
            cmd_noinc_d = rx_byte[6];
            byte_cnt_d  = '0;
            state_d     = S_ADDR;
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            cur_addr_d = (cur_addr << 8) | ADDR_W'(rx_byte);
            byte_cnt_d = byte_cnt + 2'd1;
            if (byte_cnt == LAST_CNT) begin
              state_d  = cmd_rd ? S_READ : S_WRITE;
              rd_issue = cmd_rd;
            end
          end
        end
        S_WRITE: begin
          if (rx_valid) begin
            wr_fire = 1'b1;
            if (addr_ok(cur_addr)) begin
              we_d        = 1'b1;
              reg_wdata_d = rx_byte;
            end else begin
              err_d = 1'b1;
            end
            cur_addr_d = addr_next(cur_addr, cmd_noinc);
          end
        end
        S_READ: begin
          if (rx_valid) begin
            cur_addr_d = addr_next(cur_addr, cmd_noinc);
            rd_issue   = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A read is issued for the address being entered, a write for the one being left.
    if (rd_issue) begin
      if (addr_ok(cur_addr_d)) begin
        re_d = 1'b1;
      end else begin
        err_d    = 1'b1;
        rd_err_d = 1'b1;
      end
    end
    reg_addr_d = wr_fire ? cur_addr : cur_addr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd_rd    <= 1'b0;
      cmd_noinc <= 1'b0;
      byte_cnt  <= '0;
      cur_addr  <= '0;
      reg_addr  <= '0;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      err       <= 1'b0;
      rd_err_p1 <= 1'b0;
    end else begin
      state     <= state_d;
      cmd_rd    <= cmd_rd_d;
      cmd_noinc <= cmd_noinc_d;
      byte_cnt  <= byte_cnt_d;
      cur_addr  <= cur_addr_d;
      reg_addr  <= reg_addr_d;
      reg_wdata <= reg_wdata_d;
      reg_we    <= we_d;
      reg_re    <= re_d;
      err       <= err_d;
      rd_err_p1 <= rd_err_d;
    end
  end

  // p1 -> p2: register file returns data the cycle after reg_re
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_p2 <= 1'b0;
      rd_err_p2 <= 1'b0;
    end else begin
      rd_vld_p2 <= reg_re & ~cs_n;
      rd_err_p2 <= rd_err_p1 & ~cs_n;
    end
  end

  // p2 -> tx: prefetched byte for the next SPI transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_byte <= 8'h00;
    end else if (cs_n) begin
      tx_byte <= 8'h00;
    end else if (rd_vld_p2) begin
      tx_byte <= reg_rdata;
    end else if (rd_err_p2) begin
      tx_byte <= ERR_BYTE;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: an 8-bit/16-entry instance (a) and a
// 16-bit/64-entry instance (b) share one SPI byte stream, each with its own register model.
module tb_spi_reg_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs_n;
  logic [7:0]  rx_byte;
  logic        rx_valid;

  logic [7:0]  a_tx, a_wdata, a_rdata;
  logic [7:0]  a_reg_addr;
  logic        a_we, a_re, a_busy, a_err;
  logic [7:0]  b_tx, b_wdata, b_rdata;
  logic [15:0] b_reg_addr;
  logic        b_we, b_re, b_busy, b_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_reg_bridge #(.ADDR_W(8), .REG_COUNT(16), .ERR_BYTE(8'hFF)) dut_a (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(a_tx), .reg_addr(a_reg_addr), .reg_wdata(a_wdata), .reg_we(a_we),
    .reg_re(a_re), .reg_rdata(a_rdata), .busy(a_busy), .err(a_err)
  );

  spi_reg_bridge #(.ADDR_W(16), .REG_COUNT(64), .ERR_BYTE(8'hFF)) dut_b (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(b_tx), .reg_addr(b_reg_addr), .reg_wdata(b_wdata), .reg_we(b_we),
    .reg_re(b_re), .reg_rdata(b_rdata), .busy(b_busy), .err(b_err)
  );

  logic [7:0] mem_a [0:15];
  logic [7:0] mem_b [0:63];

  always @(posedge clk) begin
    if (a_we) mem_a[a_reg_addr[3:0]] <= a_wdata;
    if (a_re) a_rdata <= mem_a[a_reg_addr[3:0]];
    if (b_we) mem_b[b_reg_addr[5:0]] <= b_wdata;
    if (b_re) b_rdata <= mem_b[b_reg_addr[5:0]];
  end

  int n_we_a = 0, n_re_a = 0, n_err_a = 0, n_we_b = 0, n_re_b = 0;
  always @(negedge clk) begin
    if (a_we)  n_we_a++;
    if (a_re)  n_re_a++;
    if (a_err) n_err_a++;
    if (b_we)  n_we_b++;
    if (b_re)  n_re_b++;
  end

  logic        s_we_a, s_re_a, s_err_a, s_we_b, s_re_b, s_err_b;
  logic [7:0]  s_addr_a, s_addr2_a, s_wd_a, s_tx_a, s_wd_b, s_tx_b;
  logic [15:0] s_addr_b, s_addr2_b;

  // rx_valid in cycle N; strobes sampled in N+1, address in N+2, tx_byte in N+3
  task automatic send(input logic [7:0] b);
    @(negedge clk); rx_byte = b; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    s_we_a = a_we; s_re_a = a_re; s_err_a = a_err; s_addr_a = a_reg_addr; s_wd_a = a_wdata;
    s_we_b = b_we; s_re_b = b_re; s_err_b = b_err; s_addr_b = b_reg_addr; s_wd_b = b_wdata;
    @(negedge clk); s_addr2_a = a_reg_addr; s_addr2_b = b_reg_addr;
    @(negedge clk); s_tx_a = a_tx; s_tx_b = b_tx;
  endtask

  task automatic cs_low();
    @(negedge clk); cs_n = 1'b0;
    #1;
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL busy_early got=%0b exp=0", a_busy); end
    @(negedge clk);
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL busy_rise got=%0b exp=1", a_busy); end
  endtask

  task automatic cs_high();
    @(negedge clk); cs_n = 1'b1;
    @(negedge clk);
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL busy_fall got=%0b exp=0", a_busy); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs_n = 1'b1; rx_byte = 8'h00; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({a_tx, a_reg_addr, a_wdata, a_we, a_re, a_busy, a_err} !== 28'h0) begin
      errors++; $display("FAIL reset_a got=%h exp=0", {a_tx, a_reg_addr, a_wdata, a_we, a_re, a_busy, a_err}); end
    checks++; if ({b_tx, b_reg_addr, b_wdata, b_we, b_re, b_busy, b_err} !== 36'h0) begin
      errors++; $display("FAIL reset_b got=%h exp=0", {b_tx, b_reg_addr, b_wdata, b_we, b_re, b_busy, b_err}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_burst();
    int err0;
    cs_low();
    err0 = n_err_a;
    send(8'h00); send(8'h0E);
    send(8'hA1);
    checks++; if ({s_we_a, s_addr_a, s_wd_a} !== {1'b1, 8'd14, 8'hA1}) begin
      errors++; $display("FAIL wr_burst0 got=%b/%0d/%h exp=1/14/a1", s_we_a, s_addr_a, s_wd_a); end
    checks++; if (s_addr2_a !== 8'd15) begin errors++; $display("FAIL wr_adv got=%0d exp=15", s_addr2_a); end
    checks++; if (s_tx_a !== 8'h00) begin errors++; $display("FAIL wr_tx got=%h exp=00", s_tx_a); end
    send(8'hB2);
    checks++; if ({s_we_a, s_addr_a, s_wd_a} !== {1'b1, 8'd15, 8'hB2}) begin
      errors++; $display("FAIL wr_burst1 got=%b/%0d/%h exp=1/15/b2", s_we_a, s_addr_a, s_wd_a); end
    send(8'hC3);
    checks++; if ({s_we_a, s_addr_a, s_wd_a} !== {1'b1, 8'd0, 8'hC3}) begin
      errors++; $display("FAIL wr_wrap got=%b/%0d/%h exp=1/0/c3", s_we_a, s_addr_a, s_wd_a); end
    checks++; if (n_err_a != err0) begin errors++; $display("FAIL wr_no_err got=%0d exp=0", n_err_a - err0); end
    cs_high();
  endtask

  task automatic test_read_burst();
    int we0;
    cs_low();
    send(8'h00); send(8'h03); send(8'h11); send(8'h22); send(8'h5A);
    cs_high();
    cs_low();
    we0 = n_we_a;
    send(8'h80);
    send(8'h03);
    checks++; if ({s_re_a, s_we_a, s_addr_a} !== {2'b10, 8'd3}) begin
      errors++; $display("FAIL rd_first got=%b%b/%0d exp=10/3", s_re_a, s_we_a, s_addr_a); end
    checks++; if (s_tx_a !== 8'h11) begin errors++; $display("FAIL rd_tx0 got=%h exp=11", s_tx_a); end
    send(8'hFF);
    checks++; if ({s_re_a, s_addr_a, s_tx_a} !== {1'b1, 8'd4, 8'h22}) begin
      errors++; $display("FAIL rd_next got=%b/%0d/%h exp=1/4/22", s_re_a, s_addr_a, s_tx_a); end
    send(8'hFF);
    checks++; if ({s_re_a, s_addr_a, s_tx_a} !== {1'b1, 8'd5, 8'h5A}) begin
      errors++; $display("FAIL rd_third got=%b/%0d/%h exp=1/5/5a", s_re_a, s_addr_a, s_tx_a); end
    checks++; if (n_we_a != we0) begin errors++; $display("FAIL rd_no_we got=%0d exp=0", n_we_a - we0); end
    cs_high();
    checks++; if (a_tx !== 8'h00) begin errors++; $display("FAIL rd_tx_idle got=%h exp=00", a_tx); end
  endtask

  task automatic test_noinc();
    cs_low();
    send(8'h40); send(8'h00); send(8'h05);
    send(8'h01);
    checks++; if ({s_we_b, s_addr_b, s_wd_b} !== {1'b1, 16'h0005, 8'h01}) begin
      errors++; $display("FAIL noinc0 got=%b/%h/%h exp=1/0005/01", s_we_b, s_addr_b, s_wd_b); end
    checks++; if (s_addr2_b !== 16'h0005) begin errors++; $display("FAIL noinc_hold got=%h exp=0005", s_addr2_b); end
    send(8'h02);
    checks++; if ({s_we_b, s_addr_b, s_wd_b} !== {1'b1, 16'h0005, 8'h02}) begin
      errors++; $display("FAIL noinc1 got=%b/%h/%h exp=1/0005/02", s_we_b, s_addr_b, s_wd_b); end
    cs_high();
  endtask

  task automatic test_out_of_range();
    cs_low();
    send(8'h80); send(8'h20);
    checks++; if ({s_err_a, s_re_a, s_tx_a} !== {2'b10, 8'hFF}) begin
      errors++; $display("FAIL oor_rd got=%b%b/%h exp=10/ff", s_err_a, s_re_a, s_tx_a); end
    send(8'h00);
    checks++; if ({s_err_a, s_re_a, s_tx_a} !== {2'b10, 8'hFF}) begin
      errors++; $display("FAIL oor_rd_inc got=%b%b/%h exp=10/ff", s_err_a, s_re_a, s_tx_a); end
    cs_high();
    cs_low();
    send(8'h00); send(8'h20); send(8'h77);
    checks++; if ({s_err_a, s_we_a} !== 2'b10) begin
      errors++; $display("FAIL oor_wr got=%b%b exp=10", s_err_a, s_we_a); end
    cs_high();
    // 0xFF is out of range and must count on to 0x00, which holds 02 from the noinc stream
    cs_low();
    send(8'h80); send(8'hFF);
    checks++; if ({s_err_a, s_re_a, s_tx_a} !== {2'b10, 8'hFF}) begin
      errors++; $display("FAIL oor_ff got=%b%b/%h exp=10/ff", s_err_a, s_re_a, s_tx_a); end
    send(8'h00);
    checks++; if ({s_err_a, s_re_a, s_addr_a, s_tx_a} !== {2'b01, 8'h00, 8'h02}) begin
      errors++; $display("FAIL oor_wrap got=%b%b/%h/%h exp=01/00/02", s_err_a, s_re_a, s_addr_a, s_tx_a); end
    cs_high();
  endtask

  task automatic test_abort();
    int we0, re0;
    cs_low();
    send(8'h80); send(8'h00);
    we0 = n_we_b; re0 = n_re_b;
    @(negedge clk); cs_n = 1'b1;
    @(negedge clk);
    checks++; if ({b_busy, b_we, b_re, b_tx} !== 11'h0) begin
      errors++; $display("FAIL abort_idle got=%b%b%b/%h exp=000/00", b_busy, b_we, b_re, b_tx); end
    repeat (3) @(negedge clk);
    checks++; if ((n_we_b != we0) || (n_re_b != re0)) begin
      errors++; $display("FAIL abort_strobes got=%0d/%0d exp=0/0", n_we_b - we0, n_re_b - re0); end
    cs_low();
    send(8'h00); send(8'h00); send(8'h07);
    send(8'h5C);
    checks++; if ({s_we_b, s_addr_b, s_wd_b} !== {1'b1, 16'h0007, 8'h5C}) begin
      errors++; $display("FAIL abort_recover got=%b/%h/%h exp=1/0007/5c", s_we_b, s_addr_b, s_wd_b); end
    cs_high();
  endtask

  task automatic test_async_reset();
    cs_low();
    send(8'h00); send(8'h01);
    @(negedge clk); rx_byte = 8'hAB; rx_valid = 1'b1;
    @(posedge clk); #2; rx_valid = 1'b0;
    checks++; if ({a_we, a_wdata} !== {1'b1, 8'hAB}) begin
      errors++; $display("FAIL arst_pre got=%b/%h exp=1/ab", a_we, a_wdata); end
    rst_n = 1'b0;
    #1;
    checks++; if ({a_tx, a_reg_addr, a_wdata, a_we, a_re, a_busy, a_err} !== 28'h0) begin
      errors++; $display("FAIL arst_now got=%h exp=0", {a_tx, a_reg_addr, a_wdata, a_we, a_re, a_busy, a_err}); end
    @(negedge clk); cs_n = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_noinc();
    test_out_of_range();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
